// File: rtl/i2c_av_config_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_av_config_arbiter
// Description : Hands the I2C controller to the auto-initializer until it is
//               done, then to a sequencer that drains runtime register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_av_config_arbiter #(
  parameter logic [7:0] DEVICE_ADDR = 8'h34,
  parameter int         FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ai_data_in,
  input  logic       ai_transfer_data,
  input  logic       ai_send_start_bit,
  input  logic       ai_send_stop_bit,
  input  logic       ai_auto_init_complete,
  output logic       ai_ack,
  output logic       ai_transfer_complete,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_reg,
  input  logic [8:0] wr_data,
  output logic [7:0] i2c_data_out,
  output logic       i2c_transfer_data,
  output logic       i2c_send_start_bit,
  output logic       i2c_send_stop_bit,
  input  logic       i2c_ack,
  input  logic       i2c_transfer_complete,
  input  logic       clear_error,
  output logic       busy,
  output logic       wr_error,
  output logic [7:0] err_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_BYTE1  = 3'd2,
    ST_BYTE2  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_STOP   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q;  // 0 = auto-initializer, 1 = sequencer
  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [7:0]         data_q, data_d;
  logic               xfer_q, xfer_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  logic        w_full, w_empty, w_push, w_pop, w_change;
  logic [15:0] w_head;

  assign w_full   = (count_q == C_FULL);
  assign w_empty  = (count_q == '0);
  assign w_push   = wr_valid & ~w_full;
  assign w_pop    = (state_q == ST_FINISH);
  assign w_head   = mem_q[rptr_q];
  assign w_change = i2c_transfer_complete & i2c_transfer_data;

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= {wr_reg, wr_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
      data_q  <= '0;
      xfer_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (ai_auto_init_complete) owner_q <= 1'b1;
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      state_q <= state_d;
      data_q  <= data_d;
      xfer_q  <= xfer_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    xfer_d  = xfer_q;
    start_d = start_q;
    stop_d  = stop_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (owner_q && !w_empty) state_d = ST_START;
      ST_START: begin
        data_d  = DEVICE_ADDR;
        start_d = 1'b1;
        xfer_d  = 1'b1;
        if (w_change) state_d = ST_BYTE1;
      end
      ST_BYTE1: begin
        data_d = w_head[15:8];
        xfer_d = 1'b1;
        if (w_change) state_d = ST_BYTE2;
      end
      ST_BYTE2: begin
        data_d = w_head[7:0];
        xfer_d = 1'b1;
        if (w_change) state_d = ST_WAIT;
      end
      ST_WAIT:   if (!i2c_transfer_complete) state_d = ST_STOP;
      ST_STOP: begin
        stop_d = 1'b1;
        if (i2c_transfer_complete) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (i2c_ack) begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    // A completing controller always wins over a fresh request
    if (i2c_transfer_complete) begin
      xfer_d  = 1'b0;
      start_d = 1'b0;
      stop_d  = 1'b0;
    end
    if (clear_error) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (!owner_q) state_d = ST_IDLE;
  end

  assign i2c_data_out         = owner_q ? data_q  : ai_data_in;
  assign i2c_transfer_data    = owner_q ? xfer_q  : ai_transfer_data;
  assign i2c_send_start_bit   = owner_q ? start_q : ai_send_start_bit;
  assign i2c_send_stop_bit    = owner_q ? stop_q  : ai_send_stop_bit;
  assign ai_ack               = owner_q ? 1'b0 : i2c_ack;
  assign ai_transfer_complete = owner_q ? 1'b0 : i2c_transfer_complete;
  assign wr_ready             = ~w_full;
  assign busy                 = (state_q != ST_IDLE) | ~w_empty;
  assign wr_error             = err_q;
  assign err_count            = cnt_q;

endmodule
`default_nettype wire
